cap_sensor_scanner: RTL and testbench
=====================================

Name: cap_sensor_scanner

Overview:
- Sequences the 9 capacitive touch pads one at a time using a discharge/release/measure cycle.
- Counts clock cycles until each pad's sense input rises, and publishes the result as the packed 288-bit sensor_readings bus read by the execute stage's cap instruction.
- Sits between the board pad pins and the processor; runs autonomously while enabled.
- Slot k of sensor_readings is pad k, matching the cap index decode 0..8.

Parameters:
- NUM_PADS, 9, number of pads scanned; slot width is fixed at 32.
- DISCHARGE_CYCLES, 64, cycles each pad is held low before measurement (≥1).
- TIMEOUT, 65535, saturation count when a pad never rises; must be < 2^32.

Ports:
- clock  in  1  system clock; all state on posedge.
- resetn  in  1  asynchronous, active-low reset.
- enable  in  1  level; 1 = scan continuously, 0 = stop after the current pad completes.
- pad_in  in  NUM_PADS  raw asynchronous pad sense levels.
- pad_drive  out  NUM_PADS  1 = drive pad k low (discharge); 0 = release (high-Z externally).
- sensor_readings  out  32*NUM_PADS  pad k count in bits [32k+31:32k].
- active_pad  out  4  index of the pad currently being processed.
- busy  out  1  high in any state other than IDLE.
- scan_done  out  1  one-cycle pulse after slot NUM_PADS-1 is written.

Behaviour:
- Reset (async assert, sync release): state=IDLE, pad index=0, counters=0, all sensor_readings slots=0, pad_drive=0, active_pad=0, busy=0, scan_done=0.
- pad_in passes through a 2-flop synchronizer per bit. All decisions use the synced value, so pad edge to decision latency is 2 cycles, and that latency is included in the counts.
- IDLE: when enable=1, enter DISCHARGE with a cleared cycle counter.
- DISCHARGE:
  - pad_drive has only bit[active_pad] set.
  - The counter increments each cycle.
  - After exactly DISCHARGE_CYCLES cycles in this state, go to MEASURE with the counter cleared.
- MEASURE:
  - pad_drive=0.
  - Each cycle: if synced pad[active_pad]=1, go to STORE with the current count. Else if count==TIMEOUT, go to STORE with TIMEOUT. Else increment the count.
  - A pad already high on the first MEASURE cycle stores 0.
- STORE (1 cycle):
  - Write the count to slot active_pad. Other slots are untouched.
  - If active_pad==NUM_PADS-1: pulse scan_done on the next cycle and wrap the index to 0.
  - Otherwise increment the index.
  - Next state is DISCHARGE if enable=1, else IDLE.
- Slots are only ever written in STORE. Readings persist indefinitely and stay readable while idle.
- Dropping enable mid-pad does not abort; the current pad completes and is stored.
- If enable is re-raised while in IDLE, the scan resumes at the saved index; it does not restart at 0.
- Asserting resetn mid-scan clears everything immediately, including pad_drive, so no pad is left driven.
- Minimum per-pad time is DISCHARGE_CYCLES+1+count+1 cycles.

Decomposition:
- Shared package cap_scan_pkg:
  - state encoding IDLE/DISCHARGE/MEASURE/STORE;
  - SLOT_W=32;
  - PAD_IDX_W=4.
- One natural sub-module: sync2, a parameterised-width 2-flop synchronizer with async active-low reset to 0. It is instantiated once with width NUM_PADS.
- The rest is a single FSM plus counters in cap_sensor_scanner.

Test Plan:
- Reset: hold resetn=0 with enable=1 → all sensor_readings=0, pad_drive=0, busy=0. Release → pad_drive=9'b000000001 from the next cycle for 64 cycles.
- Fixed response: the pad model raises pad_in[k] 10 cycles after release, for all k, with DISCHARGE_CYCLES=4 → every slot reads 11 (10 plus synchronizer latency minus first-cycle alignment, checked against the model). scan_done pulses once after pad 8; active_pad then wraps to 0.
- Timeout: pad 3 never rises, TIMEOUT=100 → slot 3=100, and the scan continues to pad 4.
- Pre-charged pad: pad_in[5] held high throughout → slot 5=0; the other slots are unaffected.
- Enable drop: deassert enable during MEASURE of pad 2 → pad 2 is stored, then IDLE with active_pad=3 and busy=0. Re-enable → DISCHARGE on pad 3.
- Reset mid-scan: assert resetn=0 during DISCHARGE of pad 6 → pad_drive=0 on the same edge and all slots=0. After release the scan restarts at pad 0.

Source files
------------

// File: rtl/cap_scan_pkg.sv
// Shared types and widths for the capacitive pad scanner.
package cap_scan_pkg;
  localparam int SLOT_W    = 32;
  localparam int PAD_IDX_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DISCHARGE,
    ST_MEASURE,
    ST_STORE
  } scan_state_e;
endpackage

// File: rtl/cap_sensor_scanner_sync2.sv
// Parameterised-width two-flop synchronizer; clears to 0 on reset.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;
endmodule

// File: rtl/cap_sensor_scanner.sv
// Round-robin discharge/release/measure sequencer for capacitive touch pads;
// each pad's rise time (in cycles, synchronizer latency included) lands in its slot.
module cap_sensor_scanner
  import cap_scan_pkg::*;
#(
  parameter int NUM_PADS         = 9,
  parameter int DISCHARGE_CYCLES = 64,
  parameter int TIMEOUT          = 65535
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       enable,
  input  logic [NUM_PADS-1:0]        pad_in,
  output logic [NUM_PADS-1:0]        pad_drive,
  output logic [SLOT_W*NUM_PADS-1:0] sensor_readings,
  output logic [PAD_IDX_W-1:0]       active_pad,
  output logic                       busy,
  output logic                       scan_done
);
  localparam logic [SLOT_W-1:0]    DC_LAST  = SLOT_W'(DISCHARGE_CYCLES - 1);
  localparam logic [SLOT_W-1:0]    TMO      = SLOT_W'(TIMEOUT);
  localparam logic [PAD_IDX_W-1:0] IDX_LAST = PAD_IDX_W'(NUM_PADS - 1);

  scan_state_e                       r_state, w_state_nxt;
  logic [SLOT_W-1:0]                 r_cnt, w_cnt_nxt;
  logic [PAD_IDX_W-1:0]              r_idx, w_idx_nxt;
  logic                              r_done, w_done_nxt;
  logic                              w_store;
  logic [NUM_PADS-1:0]               w_drive;
  logic [NUM_PADS-1:0]               w_pad_sync;
  logic [NUM_PADS-1:0][SLOT_W-1:0]   r_slots;

  sync2 #(.W(NUM_PADS)) u_sync (
    .clock  (clock),
    .resetn (resetn),
    .i_d    (pad_in),
    .o_q    (w_pad_sync)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_done  <= 1'b0;
      r_slots <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_done  <= w_done_nxt;
      if (w_store) r_slots[r_idx] <= r_cnt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_done_nxt  = 1'b0;
    w_store     = 1'b0;
    w_drive     = '0;
    case (r_state)
      ST_IDLE: begin
        if (enable) begin
          w_state_nxt = ST_DISCHARGE;
          w_cnt_nxt   = '0;
        end
      end
      ST_DISCHARGE: begin
        w_drive[r_idx] = 1'b1;
        if (r_cnt == DC_LAST) begin
          w_state_nxt = ST_MEASURE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      // Count is frozen on a hit or on saturation; STORE writes it as-is.
      ST_MEASURE: begin
        if (w_pad_sync[r_idx] || (r_cnt == TMO)) w_state_nxt = ST_STORE;
        else                                     w_cnt_nxt   = r_cnt + 1'b1;
      end
      ST_STORE: begin
        w_store   = 1'b1;
        w_cnt_nxt = '0;
        if (r_idx == IDX_LAST) begin
          w_idx_nxt  = '0;
          w_done_nxt = 1'b1;
        end else begin
          w_idx_nxt = r_idx + 1'b1;
        end
        w_state_nxt = enable ? ST_DISCHARGE : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign pad_drive       = w_drive;
  assign sensor_readings = r_slots;
  assign active_pad      = r_idx;
  assign busy            = (r_state != ST_IDLE);
  assign scan_done       = r_done;
endmodule

// File: tb/tb_cap_sensor_scanner.sv
// Bench for cap_sensor_scanner: RC pad model plus per-pad expected-count model.
module tb_cap_sensor_scanner;
  localparam int NP    = 9;
  localparam int DC    = 4;
  localparam int TMO   = 100;
  localparam int NEVER = 1000000;

  logic              clock = 1'b0;
  logic              resetn = 1'b0;
  logic              enable = 1'b0;
  logic [NP-1:0]     pad_in = '0;
  logic [NP-1:0]     pad_drive;
  logic [32*NP-1:0]  sensor_readings;
  logic [3:0]        active_pad;
  logic              busy;
  logic              scan_done;

  int rise [NP];
  bit pre  [NP];
  int rel  [NP];
  int n_chk = 0;
  int n_pass = 0;

  cap_sensor_scanner #(.NUM_PADS(NP), .DISCHARGE_CYCLES(DC), .TIMEOUT(TMO)) dut (
    .clock           (clock),
    .resetn          (resetn),
    .enable          (enable),
    .pad_in          (pad_in),
    .pad_drive       (pad_drive),
    .sensor_readings (sensor_readings),
    .active_pad      (active_pad),
    .busy            (busy),
    .scan_done       (scan_done)
  );

  always #5 clock = ~clock;

  // Pad k is pulled low while driven; once released it reads high after rise[k] cycles.
  always @(negedge clock) begin
    for (int k = 0; k < NP; k++) begin
      if (pre[k]) begin
        pad_in[k] = 1'b1;
      end else if (pad_drive[k]) begin
        rel[k] = 0;
        pad_in[k] = 1'b0;
      end else begin
        if (rel[k] < NEVER) rel[k] = rel[k] + 1;
        pad_in[k] = (rel[k] >= rise[k]);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Sense edge is seen two synchronizer stages later; the first measure cycle counts as 0.
  function automatic int exp_cnt(int k);
    int e;
    if (pre[k]) return 0;
    e = rise[k] + 1;
    return (e > TMO) ? TMO : e;
  endfunction

  function automatic logic [31:0] slot(int k);
    return sensor_readings[32*k +: 32];
  endfunction

  task automatic wait_scan(input string tag);
    bit seen = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clock);
      if (scan_done) seen = 1;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_wrap_idx"}, 32'(active_pad), 32'd0);
    for (int k = 0; k < NP; k++) chk($sformatf("%s_slot%0d", tag, k), slot(k), 32'(exp_cnt(k)));
    @(negedge clock);
    chk({tag, "_done_pulse"}, 32'(scan_done), 32'd0);
  endtask

  task automatic set_all(input int r);
    for (int k = 0; k < NP; k++) begin
      rise[k] = r;
      pre[k] = 0;
    end
  endtask

  initial begin
    bit hit;
    set_all(10);
    for (int k = 0; k < NP; k++) rel[k] = 0;
    resetn = 1'b0;
    enable = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_slots", 32'(|sensor_readings), 32'd0);
    chk("rst_drive", 32'(pad_drive), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_idx", 32'(active_pad), 32'd0);
    chk("rst_done", 32'(scan_done), 32'd0);

    resetn = 1'b1;
    for (int i = 0; i < DC; i++) begin
      @(negedge clock);
      chk($sformatf("dis_drive_%0d", i), 32'(pad_drive), 32'd1);
    end
    @(negedge clock);
    chk("meas_drive", 32'(pad_drive), 32'd0);
    wait_scan("fixed");

    set_all(10);
    rise[3] = NEVER;
    pre[5] = 1;
    wait_scan("tmo_pre");

    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < NP; k++) begin
        int sel = $urandom_range(0, 7);
        pre[k] = (sel == 0);
        rise[k] = (sel == 1) ? NEVER : int'($urandom_range(1, 120));
      end
      wait_scan($sformatf("rnd%0d", s));
    end

    set_all(10);
    wait_scan("refill");

    // Drop enable while pad 2 is measuring.
    rise[2] = 30;
    hit = 0;
    for (int i = 0; i < 3000 && !hit; i++) begin
      @(negedge clock);
      if (busy && active_pad == 4'd2 && pad_drive == '0) hit = 1;
    end
    chk("en_drop_reach", 32'(hit), 32'd1);
    enable = 1'b0;
    hit = 0;
    for (int i = 0; i < 500 && !hit; i++) begin
      @(negedge clock);
      if (!busy) hit = 1;
    end
    chk("en_drop_idle", 32'(hit), 32'd1);
    chk("en_drop_idx", 32'(active_pad), 32'd3);
    chk("en_drop_slot2", slot(2), 32'(exp_cnt(2)));
    repeat (10) @(negedge clock);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_drive", 32'(pad_drive), 32'd0);
    chk("idle_slot2", slot(2), 32'(exp_cnt(2)));
    chk("idle_slot8", slot(8), 32'(exp_cnt(8)));
    enable = 1'b1;
    @(negedge clock);
    chk("resume_drive", 32'(pad_drive), 32'h8);
    chk("resume_idx", 32'(active_pad), 32'd3);

    // Reset while pad 6 is discharging.
    hit = 0;
    for (int i = 0; i < 3000 && !hit; i++) begin
      @(negedge clock);
      if (pad_drive == 9'h040) hit = 1;
    end
    chk("mid_rst_reach", 32'(hit), 32'd1);
    resetn = 1'b0;
    #1;
    chk("mid_rst_drive", 32'(pad_drive), 32'd0);
    chk("mid_rst_slots", 32'(|sensor_readings), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_idx", 32'(active_pad), 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    chk("restart_drive", 32'(pad_drive), 32'd1);
    set_all(10);
    rise[7] = 55;
    wait_scan("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
